// File: rtl/addr_phase_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | addr_phase_ctrl : I2C master address-phase sequencer, 7/10-bit + retry   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module addr_phase_ctrl #(
  parameter int CSIZE     = 4,
  parameter int MODULE_ID = 0,
  parameter int MAX_RETRY = 3,
  parameter int RETRY_GAP = 16
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             exec_addr,
  input  logic             ten_bit,
  input  logic             wr_or_rd,
  input  logic [9:0]       addr,
  output logic             exec_addr_finish,
  output logic             addr_ack_ok,
  output logic             addr_nack,
  output logic             addr_timeout,
  output logic [3:0]       retry_cnt,
  output logic             tras_cmd_vld,
  output logic [CSIZE-1:0] tras_cmd,
  input  logic             tras_cmd_ready,
  output logic [3:0]       tras_cmd_mid,
  output logic [1:0]       tras_cmd_proc_id,
  input  logic [3:0]       curr_mid,
  input  logic [1:0]       curr_proc_id,
  output logic             timeout_cnt_req,
  input  logic             timeout,
  input  logic             slaver_ack_ok,
  input  logic             slaver_nack
);

  localparam logic [CSIZE-1:0] c_cmd_idle  = CSIZE'(0);
  localparam logic [CSIZE-1:0] c_cmd_start = CSIZE'(1);
  localparam logic [CSIZE-1:0] c_cmd_one   = CSIZE'(2);
  localparam logic [CSIZE-1:0] c_cmd_zero  = CSIZE'(3);
  localparam logic [CSIZE-1:0] c_cmd_stop  = CSIZE'(4);
  localparam logic [CSIZE-1:0] c_cmd_ack   = CSIZE'(5);
  localparam logic [CSIZE-1:0] c_cmd_wr    = CSIZE'(6);
  localparam logic [CSIZE-1:0] c_cmd_rd    = CSIZE'(7);

  localparam logic [3:0] c_retry_max = 4'(MAX_RETRY);
  localparam logic [7:0] c_gap_last  = 8'(RETRY_GAP - 1);

  localparam logic [1:0] c_seg_first = 2'd0;
  localparam logic [1:0] c_seg_low   = 2'd1;
  localparam logic [1:0] c_seg_rpt   = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE, ST_START, ST_HDR, ST_RW, ST_ACK, ST_WAIT,
    ST_LOW, ST_STOP, ST_GAP, ST_FSH, ST_HOLD
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_seg, w_seg_nxt;
  logic [2:0] r_bit, w_bit_nxt;
  logic [7:0] r_gap, w_gap_nxt;
  logic       r_fail_to, w_fail_to_nxt;
  logic       r_ten, r_wr;
  logic [9:0] r_addr;

  logic       w_latch;
  logic       w_ack_nxt, w_nack_nxt, w_to_nxt;
  logic [3:0] w_retry_nxt;
  logic [1:0] w_proc_nxt;
  logic       w_vld_nxt;
  logic [CSIZE-1:0] w_cmd_nxt;
  logic [7:0] w_hdr;
  logic [7:0] w_lo;
  logic       w_unused;

  assign tras_cmd_mid = 4'(MODULE_ID);
  assign w_unused     = ^{curr_mid, curr_proc_id};

  // Header byte: 7-bit address, or the 11110 prefix plus the two high bits.
  assign w_hdr = r_ten ? {1'b0, 5'b11110, r_addr[9:8]} : {1'b0, r_addr[6:0]};
  assign w_lo  = r_addr[7:0];

  always_comb begin
    w_state_nxt   = r_state;
    w_seg_nxt     = r_seg;
    w_bit_nxt     = r_bit;
    w_gap_nxt     = r_gap;
    w_fail_to_nxt = r_fail_to;
    w_retry_nxt   = retry_cnt;
    w_ack_nxt     = addr_ack_ok;
    w_nack_nxt    = addr_nack;
    w_to_nxt      = addr_timeout;
    w_proc_nxt    = tras_cmd_proc_id;
    w_latch       = 1'b0;

    if (!exec_addr && r_state != ST_IDLE && r_state != ST_HOLD) begin
      w_state_nxt = ST_IDLE;
      w_ack_nxt   = 1'b0;
      w_nack_nxt  = 1'b0;
      w_to_nxt    = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (exec_addr) begin
          w_state_nxt = ST_START;
          w_seg_nxt   = c_seg_first;
          w_retry_nxt = 4'd0;
          w_ack_nxt   = 1'b0;
          w_nack_nxt  = 1'b0;
          w_to_nxt    = 1'b0;
          w_latch     = 1'b1;
        end
        ST_START: if (tras_cmd_ready) begin
          w_state_nxt = ST_HDR;
          w_bit_nxt   = 3'd6;
        end
        ST_HDR: if (tras_cmd_ready) begin
          if (r_bit == 3'd0) w_state_nxt = ST_RW;
          else               w_bit_nxt   = r_bit - 3'd1;
        end
        ST_LOW: if (tras_cmd_ready) begin
          if (r_bit == 3'd0) w_state_nxt = ST_ACK;
          else               w_bit_nxt   = r_bit - 3'd1;
        end
        ST_RW:  if (tras_cmd_ready) w_state_nxt = ST_ACK;
        ST_ACK: if (tras_cmd_ready) w_state_nxt = ST_WAIT;
        ST_WAIT: begin
          if (slaver_ack_ok) begin
            if (r_seg == c_seg_first && r_ten) begin
              w_state_nxt = ST_LOW;
              w_seg_nxt   = c_seg_low;
              w_bit_nxt   = 3'd7;
            end else if (r_seg == c_seg_low && !r_wr) begin
              w_state_nxt = ST_START;
              w_seg_nxt   = c_seg_rpt;
            end else begin
              w_state_nxt = ST_FSH;
              w_ack_nxt   = 1'b1;
            end
          end else if (slaver_nack || timeout) begin
            w_state_nxt   = ST_STOP;
            w_fail_to_nxt = !slaver_nack;
          end
        end
        ST_STOP: if (tras_cmd_ready) begin
          if (retry_cnt < c_retry_max) begin
            w_state_nxt = ST_GAP;
            w_gap_nxt   = c_gap_last;
            w_retry_nxt = retry_cnt + 4'd1;
          end else begin
            w_state_nxt = ST_FSH;
            w_nack_nxt  = !r_fail_to;
            w_to_nxt    = r_fail_to;
          end
        end
        ST_GAP: begin
          if (r_gap == 8'd0) begin
            w_state_nxt = ST_START;
            w_seg_nxt   = c_seg_first;
          end else begin
            w_gap_nxt = r_gap - 8'd1;
          end
        end
        ST_FSH:  w_state_nxt = ST_HOLD;
        ST_HOLD: if (!exec_addr) w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    // FSH lasts exactly one cycle, so entering it is the done event.
    if (w_state_nxt == ST_FSH) w_proc_nxt = tras_cmd_proc_id + 2'd1;
  end

  // Outputs are registered from the next state so a held command stays put.
  always_comb begin
    w_cmd_nxt = c_cmd_idle;
    w_vld_nxt = 1'b1;
    case (w_state_nxt)
      ST_START: w_cmd_nxt = c_cmd_start;
      ST_HDR:   w_cmd_nxt = w_hdr[w_bit_nxt] ? c_cmd_one : c_cmd_zero;
      ST_LOW:   w_cmd_nxt = w_lo[w_bit_nxt]  ? c_cmd_one : c_cmd_zero;
      ST_RW:    w_cmd_nxt = (w_seg_nxt == c_seg_rpt || (!r_ten && !r_wr)) ? c_cmd_rd : c_cmd_wr;
      ST_ACK:   w_cmd_nxt = c_cmd_ack;
      ST_STOP:  w_cmd_nxt = c_cmd_stop;
      default:  w_vld_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= ST_IDLE;
      r_seg            <= c_seg_first;
      r_bit            <= 3'd0;
      r_gap            <= 8'd0;
      r_fail_to        <= 1'b0;
      r_ten            <= 1'b0;
      r_wr             <= 1'b0;
      r_addr           <= 10'd0;
      exec_addr_finish <= 1'b0;
      addr_ack_ok      <= 1'b0;
      addr_nack        <= 1'b0;
      addr_timeout     <= 1'b0;
      retry_cnt        <= 4'd0;
      tras_cmd_vld     <= 1'b0;
      tras_cmd         <= c_cmd_idle;
      tras_cmd_proc_id <= 2'd0;
      timeout_cnt_req  <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_seg            <= w_seg_nxt;
      r_bit            <= w_bit_nxt;
      r_gap            <= w_gap_nxt;
      r_fail_to        <= w_fail_to_nxt;
      if (w_latch) begin
        r_ten  <= ten_bit;
        r_wr   <= wr_or_rd;
        r_addr <= addr;
      end
      exec_addr_finish <= (w_state_nxt == ST_FSH);
      addr_ack_ok      <= w_ack_nxt;
      addr_nack        <= w_nack_nxt;
      addr_timeout     <= w_to_nxt;
      retry_cnt        <= w_retry_nxt;
      tras_cmd_vld     <= w_vld_nxt;
      tras_cmd         <= w_cmd_nxt;
      tras_cmd_proc_id <= w_proc_nxt;
      timeout_cnt_req  <= (w_state_nxt == ST_WAIT);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_addr_phase_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_addr_phase_ctrl : directed self-checking bench for addr_phase_ctrl     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_addr_phase_ctrl;

  localparam logic [3:0] C_S = 4'd1, C_1 = 4'd2, C_0 = 4'd3, C_P = 4'd4;
  localparam logic [3:0] C_A = 4'd5, C_W = 4'd6, C_R = 4'd7;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       exec_addr, ten_bit, wr_or_rd;
  logic [9:0] addr;
  logic       exec_addr_finish, addr_ack_ok, addr_nack, addr_timeout;
  logic [3:0] retry_cnt;
  logic       tras_cmd_vld;
  logic [3:0] tras_cmd;
  logic       tras_cmd_ready;
  logic [3:0] tras_cmd_mid;
  logic [1:0] tras_cmd_proc_id;
  logic       timeout_cnt_req, timeout, slaver_ack_ok, slaver_nack;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];
  int         gap_q[$];
  int         tcyc_q[$];
  int         resp_q[$];   // 1 ack, 2 nack, 3 timeout, 4 ack+nack together
  logic [3:0] seq_w50 [10];
  logic [3:0] seq_r3c [10];

  always #5 clock = ~clock;

  addr_phase_ctrl #(
    .CSIZE(4), .MODULE_ID(10), .MAX_RETRY(2), .RETRY_GAP(16)
  ) dut (
    .clock(clock), .rst_n(rst_n), .exec_addr(exec_addr), .ten_bit(ten_bit),
    .wr_or_rd(wr_or_rd), .addr(addr), .exec_addr_finish(exec_addr_finish),
    .addr_ack_ok(addr_ack_ok), .addr_nack(addr_nack), .addr_timeout(addr_timeout),
    .retry_cnt(retry_cnt), .tras_cmd_vld(tras_cmd_vld), .tras_cmd(tras_cmd),
    .tras_cmd_ready(tras_cmd_ready), .tras_cmd_mid(tras_cmd_mid),
    .tras_cmd_proc_id(tras_cmd_proc_id), .curr_mid(4'd0), .curr_proc_id(2'd0),
    .timeout_cnt_req(timeout_cnt_req), .timeout(timeout),
    .slaver_ack_ok(slaver_ack_ok), .slaver_nack(slaver_nack)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Runs one operation to its done pulse, collecting accepted commands and gaps.
  task automatic run_op(input string tag, input bit ten, input bit wr, input logic [9:0] a,
                        input bit tog, input bit ea, input bit en, input bit et,
                        input int eretry, input int epid, input int egaps);
    int  wait_cyc, gapn, errs, r;
    bit  in_gap, done, prev_hold, exp_req, exp_noreq, prev_evt;
    logic [3:0] prev_cmd;
    got_q.delete(); gap_q.delete(); tcyc_q.delete();
    ten_bit = ten; wr_or_rd = wr; addr = a; exec_addr = 1'b1; tras_cmd_ready = 1'b1;
    wait_cyc = 0; gapn = 0; errs = 0; in_gap = 0; done = 0; prev_hold = 0;
    exp_req = 0; exp_noreq = 0; prev_evt = 0; prev_cmd = 4'd0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(posedge clock); #1;
      slaver_ack_ok = 1'b0; slaver_nack = 1'b0; timeout = 1'b0;
      if (cyc == 0) begin
        check_val($sformatf("%s_start_vld", tag), tras_cmd_vld, 1);
        check_val($sformatf("%s_start_cmd", tag), tras_cmd, C_S);
      end
      if (exp_req && !timeout_cnt_req) errs++;
      if (exp_noreq && timeout_cnt_req) errs++;
      exp_req = 0; exp_noreq = 0;
      if (prev_hold && (!tras_cmd_vld || tras_cmd != prev_cmd)) errs++;
      if (timeout_cnt_req && tras_cmd_vld) errs++;
      if (exec_addr_finish) begin
        done = 1;
        if (!prev_evt) errs++;
      end else begin
        prev_evt = 0;
        if (in_gap) begin
          if (tras_cmd_vld) begin gap_q.push_back(gapn); in_gap = 0; end
          else gapn++;
        end
        if (timeout_cnt_req) begin
          wait_cyc++;
          if (wait_cyc == 3 && resp_q.size() > 0) begin
            r = resp_q.pop_front();
            slaver_ack_ok = (r == 1 || r == 4);
            slaver_nack   = (r == 2 || r == 4);
            timeout       = (r == 3);
            exp_noreq = 1; prev_evt = 1;
          end
        end else wait_cyc = 0;
        tras_cmd_ready = tog ? !tras_cmd_ready : 1'b1;
        if (tras_cmd_vld && tras_cmd_ready) begin
          got_q.push_back(tras_cmd); tcyc_q.push_back(cyc);
          if (tras_cmd == C_A) exp_req = 1;
          if (tras_cmd == C_P) begin in_gap = 1; gapn = 0; prev_evt = 1; end
        end
        prev_hold = tras_cmd_vld && !tras_cmd_ready;
        prev_cmd  = tras_cmd;
      end
    end
    check_val($sformatf("%s_done", tag), done, 1);
    check_val($sformatf("%s_ack_ok", tag), addr_ack_ok, ea);
    check_val($sformatf("%s_nack", tag), addr_nack, en);
    check_val($sformatf("%s_timeout", tag), addr_timeout, et);
    check_val($sformatf("%s_retry", tag), retry_cnt, eretry);
    check_val($sformatf("%s_proc_id", tag), tras_cmd_proc_id, epid);
    check_val($sformatf("%s_protocol_errs", tag), errs, 0);
    check_val($sformatf("%s_ncmd", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check_val($sformatf("%s_cmd%0d", tag, i), (i < got_q.size()) ? int'(got_q[i]) : 15, exp_q[i]);
    check_val($sformatf("%s_ngaps", tag), gap_q.size(), egaps);
    foreach (gap_q[i]) check_val($sformatf("%s_gap%0d", tag, i), gap_q[i], 16);
    // Held request must not re-run the operation.
    errs = 0;
    repeat (4) begin
      @(posedge clock); #1;
      if (tras_cmd_vld || exec_addr_finish) errs++;
    end
    check_val($sformatf("%s_hold_quiet", tag), errs, 0);
    exec_addr = 1'b0;
    @(posedge clock); #1;
  endtask

  initial begin
    int n;
    bit found;
    seq_w50 = '{C_S, C_1, C_0, C_1, C_0, C_0, C_0, C_0, C_W, C_A};
    seq_r3c = '{C_S, C_0, C_1, C_1, C_1, C_1, C_0, C_0, C_R, C_A};
    rst_n = 1'b0; exec_addr = 1'b0; ten_bit = 1'b0; wr_or_rd = 1'b0; addr = 10'd0;
    tras_cmd_ready = 1'b0; timeout = 1'b0; slaver_ack_ok = 1'b0; slaver_nack = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_val("rst_vld", tras_cmd_vld, 0);
    check_val("rst_cmd", tras_cmd, 0);
    check_val("rst_finish", exec_addr_finish, 0);
    check_val("rst_proc_id", tras_cmd_proc_id, 0);
    check_val("rst_req", timeout_cnt_req, 0);
    check_val("rst_mid", tras_cmd_mid, 10);
    rst_n = 1'b1;
    @(posedge clock); #1;

    // 7-bit write 0x050, ready always high
    exp_q.delete(); foreach (seq_w50[i]) exp_q.push_back(seq_w50[i]);
    resp_q = '{1};
    run_op("t1", 1'b0, 1'b1, 10'h050, 1'b0, 1, 0, 0, 0, 1, 0);
    check_val("t1_consecutive", (tcyc_q.size() == 10) ? tcyc_q[9] - tcyc_q[0] : -1, 9);

    // same with ready toggling
    resp_q = '{1};
    run_op("t2", 1'b0, 1'b1, 10'h050, 1'b1, 1, 0, 0, 0, 2, 0);

    // 10-bit read 0x2A5
    exp_q = '{C_S, C_1, C_1, C_1, C_1, C_0, C_1, C_0, C_W, C_A,
              C_1, C_0, C_1, C_0, C_0, C_1, C_0, C_1, C_A,
              C_S, C_1, C_1, C_1, C_1, C_0, C_1, C_0, C_R, C_A};
    resp_q = '{1, 1, 1};
    run_op("t3", 1'b1, 1'b0, 10'h2A5, 1'b0, 1, 0, 0, 0, 3, 0);

    // 10-bit write 0x1C3, proc_id wraps 3 -> 0
    exp_q = '{C_S, C_1, C_1, C_1, C_1, C_0, C_0, C_1, C_W, C_A,
              C_1, C_1, C_0, C_0, C_0, C_0, C_1, C_1, C_A};
    resp_q = '{1, 1};
    run_op("t10w", 1'b1, 1'b1, 10'h1C3, 1'b0, 1, 0, 0, 0, 0, 0);

    // 7-bit read 0x3C, nack on all three attempts
    exp_q.delete();
    repeat (3) begin
      foreach (seq_r3c[i]) exp_q.push_back(seq_r3c[i]);
      exp_q.push_back(C_P);
    end
    resp_q = '{2, 2, 2};
    run_op("t4", 1'b0, 1'b0, 10'h03C, 1'b0, 0, 1, 0, 2, 1, 2);

    // timeout first, then ack+nack together counts as ack
    exp_q.delete();
    foreach (seq_w50[i]) exp_q.push_back(seq_w50[i]);
    exp_q.push_back(C_P);
    foreach (seq_w50[i]) exp_q.push_back(seq_w50[i]);
    resp_q = '{3, 4};
    run_op("t5", 1'b0, 1'b1, 10'h050, 1'b0, 1, 0, 0, 1, 2, 1);

    // abort after the 4th address bit
    ten_bit = 1'b0; wr_or_rd = 1'b1; addr = 10'h050; tras_cmd_ready = 1'b1; exec_addr = 1'b1;
    repeat (6) begin @(posedge clock); #1; end
    check_val("t6_fifth_bit", tras_cmd, C_0);
    exec_addr = 1'b0; tras_cmd_ready = 1'b0;
    @(posedge clock); #1;
    check_val("t6_abort_vld", tras_cmd_vld, 0);
    check_val("t6_abort_cmd", tras_cmd, 0);
    n = 0;
    repeat (4) begin
      if (exec_addr_finish) n++;
      @(posedge clock); #1;
    end
    check_val("t6_no_done", n, 0);
    check_val("t6_proc_id", tras_cmd_proc_id, 2);
    check_val("t6_ack_cleared", addr_ack_ok, 0);

    // reset asserted while waiting for the slave ack
    tras_cmd_ready = 1'b1; exec_addr = 1'b1; found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clock); #1;
      if (timeout_cnt_req) found = 1;
    end
    check_val("t6_reached_wait", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("t6_rst_vld", tras_cmd_vld, 0);
    check_val("t6_rst_req", timeout_cnt_req, 0);
    check_val("t6_rst_cmd", tras_cmd, 0);
    check_val("t6_rst_proc_id", tras_cmd_proc_id, 0);
    check_val("t6_rst_mid", tras_cmd_mid, 10);
    exec_addr = 1'b0;
    @(posedge clock); #1;
    rst_n = 1'b1;
    @(posedge clock); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/addr_phase_ctrl.md
# addr_phase_ctrl

Parametrised I2C master address-phase sequencer, successor to the 7-bit-only address controller in `byte_stage_ctrl`. It supports 7-bit and 10-bit slave addressing, selected at run time. For 10-bit reads it inserts a repeated START automatically. On NACK or timeout it retries a configurable number of times, with a STOP and an idle gap between attempts. It drives the shared 4-tap transmit command interface and reports ack/nack/timeout status to the byte-stage controller.

## Interface
- `CSIZE`, 4, width of `tras_cmd`; command codes come from `parameter_package`:
  - IDLE=0, START=1, 1=2, 0=3, STOP=4, ACK=5, WR=6, RD=7.
- `MODULE_ID`, 0, constant driven on `tras_cmd_mid`.
- `MAX_RETRY`, 3, number of extra attempts after the first (0..15).
- `RETRY_GAP`, 16, idle cycles between a retry STOP and the next START (1..255).

Ports:
- `clock`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `exec_addr`  in  1  level request; held high for the whole operation; low aborts.
- `ten_bit`  in  1  1 = 10-bit address, 0 = 7-bit; sampled at operation start.
- `wr_or_rd`  in  1  WR:1 RD:0; sampled at operation start.
- `addr`  in  10  slave address; 7-bit mode uses `addr[6:0]`; sampled at operation start.
- `exec_addr_finish`  out  1  one-cycle done pulse.
- `addr_ack_ok`, `addr_nack`, `addr_timeout`  out  1 each  final status, one-hot, valid with the done pulse.
- `retry_cnt`  out  4  retries consumed in the current/last operation.
- `tras_cmd_vld`  out  1  command valid.
- `tras_cmd`  out  CSIZE  command code.
- `tras_cmd_ready`  in  1  command accepted when high together with `vld`.
- `tras_cmd_mid`  out  4  `MODULE_ID`.
- `tras_cmd_proc_id`  out  2  process id.
- `curr_mid`, `curr_proc_id`  in  4/2  unused; kept for tap compatibility.
- `timeout_cnt_req`  out  1  high while waiting for the slave ack.
- `timeout`, `slaver_ack_ok`, `slaver_nack`  in  1 each  ack-wait results.

## Operation
- States: `IDLE`, `START`, `HDR`, `RW`, `ACK`, `WAIT`, `LOW`, `STOP`, `GAP`, `FSH`, `HOLD`.
- `IDLE`→`START` when `exec_addr` is high. On this transition:
  - latch `ten_bit`, `wr_or_rd`, `addr`;
  - clear the status flags and `retry_cnt`.
- Per-mode command sequences; all bits MSB first, each bit sent as CMD_1 or CMD_0:
  - 7-bit: START, `addr[6:0]`, WR/RD, ACK, wait.
  - 10-bit write: START, 1,1,1,1,0, `addr[9:8]`, WR, ACK, wait; then `addr[7:0]`, ACK, wait.
  - 10-bit read: the 10-bit write sequence, then START (repeated), 1,1,1,1,0, `addr[9:8]`, RD, ACK, wait.
- `WAIT` is entered after ACK is accepted.
  - `timeout_cnt_req`=1 and `tras_cmd_vld`=0 while in `WAIT`.
  - Priority of results: `slaver_ack_ok` > `slaver_nack` > `timeout`.
- Ack received: continue to the next segment, or go to `FSH` with `addr_ack_ok`=1 after the last segment.
- Nack or timeout with `retry_cnt` < `MAX_RETRY`:
  - issue STOP, then `GAP` for `RETRY_GAP` cycles;
  - increment `retry_cnt`;
  - restart at `START` from the first segment.
- Nack or timeout with `retry_cnt` = `MAX_RETRY`: issue STOP, then `FSH` with `addr_nack` or `addr_timeout` set (whichever caused the final failure).
- `FSH`:
  - pulse `exec_addr_finish`;
  - increment `tras_cmd_proc_id` (wraps 3→0);
  - go to `HOLD`.
- `HOLD` waits for `exec_addr`=0, then returns to `IDLE`. The operation does not re-run while `exec_addr` stays high.
- Abort: `exec_addr`=0 in any state other than `HOLD`.
  - Next state is `IDLE`; `tras_cmd_vld`, `timeout_cnt_req` and `tras_cmd` (IDLE) are cleared next cycle.
  - No done pulse, `proc_id` unchanged, status flags cleared.
- Reset values: all outputs 0, `tras_cmd`=CMD_IDLE (0), `tras_cmd_mid`=`MODULE_ID`. Reset mid-operation returns everything to these values immediately.

## Timing
- All outputs are registered except `tras_cmd_mid`.
- First command (START) is visible the cycle after `exec_addr` is first sampled high.
- Handshake:
  - transfer happens on a cycle where `vld`&&`ready`;
  - `tras_cmd` is stable while `vld`=1 and `ready`=0;
  - the next command appears the cycle after acceptance, with `vld` staying high back-to-back inside a segment.
- With `ready` tied to 1, commands flow at one per cycle:
  - 7-bit: 10 commands;
  - 10-bit write: 19 commands;
  - 10-bit read: 29 commands.
- `timeout_cnt_req` rises the cycle after ACK acceptance. It falls the cycle after a result is sampled.
- `exec_addr_finish` pulses 1 cycle after the final ack is sampled, or 1 cycle after the final STOP is accepted.
- `GAP` lasts exactly `RETRY_GAP` cycles with `vld`=0.

## Test plan
1. 7-bit write, `addr`=0x050, `ready`=1, `slaver_ack_ok` 3 cycles into `WAIT` -> commands START,1,0,1,0,0,0,0,WR,ACK on 10 consecutive cycles; done pulse with `addr_ack_ok`=1, `retry_cnt`=0; `proc_id` 0→1.
2. Same as 1 with `ready` toggling every cycle -> identical sequence; each code held unchanged until accepted.
3. 10-bit read, `addr`=0x2A5, acks each time -> START,1,1,1,1,0,1,0,WR,ACK | 1,0,1,0,0,1,0,1,ACK | START,1,1,1,1,0,1,0,RD,ACK (29 commands); done with `addr_ack_ok`=1.
4. `MAX_RETRY`=2, `slaver_nack` on every attempt -> 3 attempts, STOP after each, 16-cycle gaps; done with `addr_nack`=1, `retry_cnt`=2.
5. `timeout` on the first attempt, ack on the second -> one STOP plus gap; done with `addr_ack_ok`=1, `addr_timeout`=0, `retry_cnt`=1; `slaver_ack_ok` and `slaver_nack` in the same cycle count as ack.
6. `exec_addr` dropped after the 4th address bit -> next cycle `vld`=0, no done pulse, `proc_id` unchanged. Then `rst_n` asserted mid-`WAIT` -> all outputs to reset values without waiting for a clock edge.
